// File: rtl/rs_sched_pkg.sv
// Shared types and helpers for the reservation-station issue scheduler.
package rs_sched_pkg;

  localparam int NUM_RS_DEFAULT = 4;
  localparam int IDX_W_DEFAULT  = $clog2(NUM_RS_DEFAULT);

  typedef logic [NUM_RS_DEFAULT-1:0] rs_vec_t;
  typedef logic [IDX_W_DEFAULT-1:0]  rs_idx_t;

  function automatic rs_idx_t onehot_to_idx(input rs_vec_t v);
    rs_idx_t r;
    r = '0;
    for (int i = 0; i < NUM_RS_DEFAULT; i++)
      if (v[i]) r = r | rs_idx_t'(i);
    return r;
  endfunction

endpackage

// File: rtl/rs_issue_scheduler_rr_picker.sv
// Rotating priority encoder: first set bit at or after ptr_i, wrapping.
module rs_rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  logic [IW-1:0] k;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found_o  = 1'b0;
    k        = '0;
    for (int off = 0; off < N; off++) begin
      k = IW'((int'(ptr_i) + off) % N);
      if (!found_o && vec_i[k]) begin
        onehot_o[k] = 1'b1;
        idx_o       = k;
        found_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_issue_scheduler.sv
// RS bank controller: round-robin allocation plus oldest-ready issue
// selection driven by a pairwise age matrix.
module rs_issue_scheduler
  import rs_sched_pkg::*;
#(
  parameter int NUM_RS     = NUM_RS_DEFAULT,
  parameter int ROBsize    = 32,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int IDX_W      = $clog2(NUM_RS)
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              flush_i,
  input  logic              alloc_req_i,
  input  logic [NUM_RS-1:0] rs_busy_i,
  input  logic [NUM_RS-1:0] rs_ready_i,
  output logic [NUM_RS-1:0] alloc_grant_o,
  output logic              stall_o,
  input  logic              fu_ready_i,
  output logic [NUM_RS-1:0] issue_sel_o,
  output logic [IDX_W-1:0]  issue_idx_o,
  output logic              issue_valid_o
);

  if (NUM_RS < 2 || ROBsizeLog < 1) begin : g_bad_cfg
    $error("rs_issue_scheduler: bad NUM_RS/ROBsize");
  end

  // older_q[j][i] = 1 when entry j was allocated before entry i
  logic [NUM_RS-1:0][NUM_RS-1:0] older_q, older_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [NUM_RS-1:0] pick_oh, cand, win_raw, winner;
  logic [NUM_RS-1:0] issue_sel, alloc_grant;
  logic [IDX_W-1:0]  pick_idx, win_idx;
  logic              pick_found, alloc_fire, issue_en;

  rs_rr_picker #(.N(NUM_RS), .IW(IDX_W)) u_alloc_pick (
    .vec_i    (~rs_busy_i),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .found_o  (pick_found)
  );

  always_comb begin
    cand    = rs_busy_i & rs_ready_i;
    win_raw = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      win_raw[k] = cand[k];
      for (int j = 0; j < NUM_RS; j++)
        if (cand[j] && older_q[j][k]) win_raw[k] = 1'b0;
    end
  end

  // equal-age survivors (after reset/flush) fall to the lowest index
  assign winner = win_raw & (~win_raw + NUM_RS'(1));

  if (NUM_RS == NUM_RS_DEFAULT) begin : g_enc_pkg
    assign win_idx = onehot_to_idx(winner);
  end else begin : g_enc_loop
    always_comb begin
      win_idx = '0;
      for (int k = 0; k < NUM_RS; k++)
        if (winner[k]) win_idx = IDX_W'(k);
    end
  end

  assign issue_en    = fu_ready_i & ~flush_i & reset_n_i;
  assign issue_sel   = winner & {NUM_RS{issue_en}};
  assign alloc_fire  = alloc_req_i & pick_found & ~flush_i & reset_n_i;
  assign alloc_grant = pick_oh & {NUM_RS{alloc_fire}};

  assign alloc_grant_o = alloc_grant;
  assign stall_o       = (&rs_busy_i) & reset_n_i;
  assign issue_sel_o   = issue_sel;
  assign issue_idx_o   = win_idx & {IDX_W{reset_n_i}};
  assign issue_valid_o = |issue_sel;

  always_comb begin
    older_d  = older_q;
    rr_ptr_d = rr_ptr_q;
    if (flush_i) begin
      older_d = '0;
    end else if (alloc_fire) begin
      rr_ptr_d = (pick_idx == IDX_W'(NUM_RS - 1)) ? '0
                 : pick_idx + IDX_W'(1);
      // an entry leaving this cycle is not older than the newcomer
      for (int j = 0; j < NUM_RS; j++) begin
        if (alloc_grant[j])
          older_d[j] = '0;
        else
          older_d[j] = (older_q[j] & ~alloc_grant)
                     | (alloc_grant
                        & {NUM_RS{rs_busy_i[j] & ~issue_sel[j]}});
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      older_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      older_q  <= older_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule
